// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester, response and ROM-side signals of the two-port ROM arbiter
interface rom_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport slave (
    input  req0, addr0, req1, addr1, rom_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );

  modport master (
    output req0, addr0, req1, addr1, rom_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port round-robin ROM read arbiter with burst hold
// One read per cycle; the response tag follows the single-cycle ROM latency.
module rom_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  rom_arbiter_if.slave  bus
);
  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  typedef enum logic [1:0] {TAG_IDLE, TAG_P0, TAG_P1} tag_t;

  logic                  prio;
  logic                  last_owner;
  logic [3:0]            run_cnt;
  tag_t                  rsp_tag;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  granted;
  logic                  winner;

  // Grants are gated by reset so nothing is accepted while reset_n is low.
  always_comb begin
    granted = 1'b0;
    winner  = 1'b0;
    if (reset_n) begin
      case ({bus.req1, bus.req0})
        2'b01: begin
          granted = 1'b1;
          winner  = 1'b0;
        end
        2'b10: begin
          granted = 1'b1;
          winner  = 1'b1;
        end
        2'b11: begin
          granted = 1'b1;
          if (run_cnt == 4'd0)
            winner = prio;
          else if (run_cnt < BURST_MAX)
            winner = last_owner;
          else
            winner = ~last_owner;
        end
        default: begin
          granted = 1'b0;
          winner  = 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0     = granted & ~winner;
  assign bus.gnt1     = granted & winner;
  assign bus.rom_addr = granted ? (winner ? bus.addr1 : bus.addr0) : addr_hold;

  assign bus.rvalid0  = (rsp_tag == TAG_P0);
  assign bus.rvalid1  = (rsp_tag == TAG_P1);
  assign bus.rdata0   = bus.rom_data;
  assign bus.rdata1   = bus.rom_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio       <= 1'b0;
      last_owner <= 1'b0;
      run_cnt    <= 4'd0;
      rsp_tag    <= TAG_IDLE;
      addr_hold  <= '0;
    end else if (granted) begin
      addr_hold <= bus.rom_addr;
      prio      <= ~winner;
      rsp_tag   <= winner ? TAG_P1 : TAG_P0;
      if (winner == last_owner) begin
        if (run_cnt != BURST_MAX)
          run_cnt <= run_cnt + 4'd1;
      end else begin
        last_owner <= winner;
        run_cnt    <= 4'd1;
      end
    end else begin
      run_cnt <= 4'd0;
      rsp_tag <= TAG_IDLE;
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - testbench for rom_arbiter (BURST_LEN=4 and BURST_LEN=1 instances)
module tb_rom_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rom_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) ifa ();
  rom_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) ifb ();

  rom_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .BURST_LEN(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  rom_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .BURST_LEN(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hA5C3;
  endfunction

  // Synchronous ROM: data for the address presented at an edge appears after it.
  always @(posedge clk) begin
    ifa.rom_data <= rom_word(ifa.rom_addr);
    ifb.rom_data <= rom_word(ifb.rom_addr);
  end

  int n_checks = 0;
  int n_pass   = 0;

  bit          st_r0[2];
  bit          st_r1[2];
  logic [15:0] st_a0[2];
  logic [15:0] st_a1[2];
  logic        ob_g0[2];
  logic        ob_g1[2];

  // Reference: a requester keeps the port while its current streak is below the
  // burst limit; after an idle cycle the requester not served last wins.
  int          m_blen[2] = '{4, 1};
  int          m_streak[2];
  int          m_last[2];
  int          m_served[2];
  int          m_exp_rv[2];
  logic [15:0] m_exp_data[2];
  logic [15:0] m_addr[2];
  bit          m_addr_ok[2];
  int          m_wait0[2];
  int          m_wait1[2];

  typedef struct {
    bit          do_rst;
    bit          r0;
    logic [15:0] a0;
    bit          r1;
    logic [15:0] a1;
    logic [1:0]  exp_a;
    logic [1:0]  exp_b;
  } vec_t;
  vec_t tv[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_streak[k]  = 0;
      m_last[k]    = 0;
      m_served[k]  = 1;
      m_exp_rv[k]  = -1;
      m_addr_ok[k] = 1'b0;
      m_wait0[k]   = 0;
      m_wait1[k]   = 0;
    end
  endtask

  function automatic int pick(input int k, input bit r0, input bit r1);
    if (reset_n !== 1'b1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return -1;
    if (m_streak[k] == 0) return 1 - m_served[k];
    if (m_streak[k] < m_blen[k]) return m_last[k];
    return 1 - m_last[k];
  endfunction

  task automatic check_inst(input int k);
    logic g0, g1, rv0, rv1;
    logic [15:0] ra, rd0, rd1, ea;
    int p;
    string t;
    if (k == 0) begin
      g0 = ifa.gnt0; g1 = ifa.gnt1; rv0 = ifa.rvalid0; rv1 = ifa.rvalid1;
      ra = ifa.rom_addr; rd0 = ifa.rdata0; rd1 = ifa.rdata1; t = "a";
    end else begin
      g0 = ifb.gnt0; g1 = ifb.gnt1; rv0 = ifb.rvalid0; rv1 = ifb.rvalid1;
      ra = ifb.rom_addr; rd0 = ifb.rdata0; rd1 = ifb.rdata1; t = "b";
    end
    p = pick(k, st_r0[k], st_r1[k]);
    chk({t, " gnt0"}, 32'(g0), 32'(p == 0));
    chk({t, " gnt1"}, 32'(g1), 32'(p == 1));
    ea = (p == 0) ? st_a0[k] : (p == 1) ? st_a1[k] : m_addr[k];
    if (p >= 0 || m_addr_ok[k]) chk({t, " rom_addr"}, 32'(ra), 32'(ea));
    chk({t, " rvalid0"}, 32'(rv0), 32'(m_exp_rv[k] == 0));
    chk({t, " rvalid1"}, 32'(rv1), 32'(m_exp_rv[k] == 1));
    if (m_exp_rv[k] == 0) chk({t, " rdata0"}, 32'(rd0), 32'(m_exp_data[k]));
    if (m_exp_rv[k] == 1) chk({t, " rdata1"}, 32'(rd1), 32'(m_exp_data[k]));
    if (st_r0[k] && g0 !== 1'b1) begin
      m_wait0[k]++;
      chk({t, " starve0"}, 32'(m_wait0[k] <= m_blen[k]), 32'd1);
    end else m_wait0[k] = 0;
    if (st_r1[k] && g1 !== 1'b1) begin
      m_wait1[k]++;
      chk({t, " starve1"}, 32'(m_wait1[k] <= m_blen[k]), 32'd1);
    end else m_wait1[k] = 0;
    if (p >= 0) begin
      if (p == m_last[k]) m_streak[k]++;
      else begin
        m_last[k]   = p;
        m_streak[k] = 1;
      end
      m_served[k]   = p;
      m_addr[k]     = ea;
      m_addr_ok[k]  = 1'b1;
      m_exp_rv[k]   = p;
      m_exp_data[k] = rom_word(ea);
    end else begin
      m_streak[k] = 0;
      m_exp_rv[k] = -1;
    end
    ob_g0[k] = g0;
    ob_g1[k] = g1;
  endtask

  task automatic cyc();
    ifa.req0 = st_r0[0]; ifa.addr0 = st_a0[0]; ifa.req1 = st_r1[0]; ifa.addr1 = st_a1[0];
    ifb.req0 = st_r0[1]; ifb.addr0 = st_a0[1]; ifb.req1 = st_r1[1]; ifb.addr1 = st_a1[1];
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_both(input bit r0, input logic [15:0] a0, input bit r1, input logic [15:0] a1);
    for (int k = 0; k < 2; k++) begin
      st_r0[k] = r0; st_a0[k] = a0; st_r1[k] = r1; st_a1[k] = a1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    ifb.req0 = 1'b1; ifb.req1 = 1'b1;
    #1;
    chk("rst a gnt0", 32'(ifa.gnt0), 32'd0);
    chk("rst a gnt1", 32'(ifa.gnt1), 32'd0);
    chk("rst a rvalid0", 32'(ifa.rvalid0), 32'd0);
    chk("rst a rvalid1", 32'(ifa.rvalid1), 32'd0);
    chk("rst b gnt0", 32'(ifb.gnt0), 32'd0);
    chk("rst b rvalid1", 32'(ifb.rvalid1), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 2'b01, 2'b01};
    tv[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00, 2'b00};
    tv[2]  = '{1'b1, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b01, 2'b01};
    tv[3]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b01, 2'b10};
    tv[4]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b01, 2'b01};
    tv[5]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b01, 2'b10};
    tv[6]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b10, 2'b01};
    tv[7]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b10, 2'b10};
    tv[8]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b10, 2'b01};
    tv[9]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b10, 2'b10};
    tv[10] = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b01, 2'b01};
    tv[11] = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 2'b01, 2'b10};
    tv[12] = '{1'b0, 1'b0, 16'h0100, 1'b0, 16'h0200, 2'b00, 2'b00};
    tv[13] = '{1'b0, 1'b1, 16'h0110, 1'b1, 16'h0210, 2'b10, 2'b01};
    tv[14] = '{1'b0, 1'b1, 16'h0110, 1'b1, 16'h0210, 2'b10, 2'b10};

    reset_n = 1'b1;
    set_both(1'b0, 16'h0000, 1'b0, 16'h0000);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      if (tv[i].do_rst) do_reset();
      set_both(tv[i].r0, tv[i].a0, tv[i].r1, tv[i].a1);
      cyc();
      chk($sformatf("vec%0d a grants", i), 32'({ob_g1[0], ob_g0[0]}), 32'(tv[i].exp_a));
      chk($sformatf("vec%0d b grants", i), 32'({ob_g1[1], ob_g0[1]}), 32'(tv[i].exp_b));
    end

    for (int i = 0; i < 10; i++) begin
      set_both(1'b0, 16'h0000, 1'b1, 16'h0300 + 16'(i));
      cyc();
      chk($sformatf("solo1 a gnt1 %0d", i), 32'(ob_g1[0]), 32'd1);
      chk($sformatf("solo1 b gnt1 %0d", i), 32'(ob_g1[1]), 32'd1);
    end

    set_both(1'b0, 16'h0000, 1'b1, 16'h0400);
    cyc();
    set_both(1'b1, 16'h0500, 1'b0, 16'h0000);
    cyc();
    chk("midrst a gnt0", 32'(ob_g0[0]), 32'd1);
    chk("midrst a rvalid0 before", 32'(ifa.rvalid0), 32'd1);
    chk("midrst b rvalid0 before", 32'(ifb.rvalid0), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst a rvalid0 after", 32'(ifa.rvalid0), 32'd0);
    chk("midrst b rvalid0 after", 32'(ifb.rvalid0), 32'd0);
    chk("midrst a gnt0 in reset", 32'(ifa.gnt0), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    set_both(1'b1, 16'h0600, 1'b1, 16'h0700);
    cyc();
    chk("post rst a prio", 32'(ob_g0[0]), 32'd1);
    chk("post rst b prio", 32'(ob_g0[1]), 32'd1);

    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(st_r0[k] && ob_g0[k] !== 1'b1 && $urandom_range(0, 99) >= 4)) begin
          st_r0[k] = ($urandom_range(0, 99) < 65);
          st_a0[k] = 16'($urandom);
        end
        if (!(st_r1[k] && ob_g1[k] !== 1'b1 && $urandom_range(0, 99) >= 4)) begin
          st_r1[k] = ($urandom_range(0, 99) < 65);
          st_a1[k] = 16'($urandom);
        end
      end
      cyc();
    end

    set_both(1'b0, 16'h0000, 1'b0, 16'h0000);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
